// File: rtl/game_sprite_motion.sv
// Sprite position/velocity register with a periodic motion step and an on-screen flag.
// Position wraps modulo 2^WIDTH; explicit position writes override a coincident step.
module game_sprite_motion #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int D_WIDTH       = 4,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int SPRITE_W      = 8,
    parameter int SPRITE_H      = 8,
    parameter int UPDATE_PERIOD = 100000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sprite_write_xy,
    input  logic [X_WIDTH-1:0] sprite_write_x,
    input  logic [Y_WIDTH-1:0] sprite_write_y,
    input  logic               sprite_write_dxy,
    input  logic [D_WIDTH-1:0] sprite_write_dx,
    input  logic [D_WIDTH-1:0] sprite_write_dy,
    input  logic               sprite_enable_update,
    output logic [X_WIDTH-1:0] sprite_x,
    output logic [Y_WIDTH-1:0] sprite_y,
    output logic               sprite_within_screen,
    output logic               sprite_update_tick
);
    localparam int CNT_W = $clog2(UPDATE_PERIOD);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [X_WIDTH-1:0] X_MAX    = X_WIDTH'(SCREEN_W - SPRITE_W);
    localparam logic [Y_WIDTH-1:0] Y_MAX    = Y_WIDTH'(SCREEN_H - SPRITE_H);

    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [X_WIDTH-1:0]        x_reg, x_next;
    logic [Y_WIDTH-1:0]        y_reg, y_next;
    logic signed [D_WIDTH-1:0] dx_reg, dy_reg;
    logic                      within_reg, within_next;
    logic                      tick;

    // The step is abandoned while reset is held, so no tick is reported then.
    assign tick = reset_n && sprite_enable_update && (cnt_reg == CNT_LAST);

    always_comb begin
        cnt_next = '0;
        if (sprite_enable_update && (cnt_reg != CNT_LAST)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        x_next = x_reg;
        y_next = y_reg;
        if (sprite_write_xy) begin
            x_next = sprite_write_x;
            y_next = sprite_write_y;
        end else if (tick) begin
            // Size casts of the signed velocity sign-extend it before the modular add.
            x_next = x_reg + X_WIDTH'(dx_reg);
            y_next = y_reg + Y_WIDTH'(dy_reg);
        end

        within_next = (x_next <= X_MAX) && (y_next <= Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            within_reg <= 1'b1;
        end else begin
            cnt_reg    <= cnt_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            within_reg <= within_next;
            if (sprite_write_dxy) begin
                dx_reg <= sprite_write_dx;
                dy_reg <= sprite_write_dy;
            end
        end
    end

    assign sprite_x             = x_reg;
    assign sprite_y             = y_reg;
    assign sprite_within_screen = within_reg;
    assign sprite_update_tick   = tick;
endmodule

// File: tb/tb_game_sprite_motion.sv
// Self-checking bench for game_sprite_motion with UPDATE_PERIOD=4; expected
// post-edge state is queued per cycle and compared when the DUT presents it.
module tb_game_sprite_motion;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       wxy, wdxy, en;
    logic [9:0] wx, wy;
    logic [3:0] wdx, wdy;
    logic [9:0] sprite_x, sprite_y;
    logic       sprite_within_screen, sprite_update_tick;

    always #5 clk = ~clk;

    game_sprite_motion #(.UPDATE_PERIOD(4)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .sprite_write_xy      (wxy),
        .sprite_write_x       (wx),
        .sprite_write_y       (wy),
        .sprite_write_dxy     (wdxy),
        .sprite_write_dx      (wdx),
        .sprite_write_dy      (wdy),
        .sprite_enable_update (en),
        .sprite_x             (sprite_x),
        .sprite_y             (sprite_y),
        .sprite_within_screen (sprite_within_screen),
        .sprite_update_tick   (sprite_update_tick)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       w;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   ticks  = 0;
    logic last_tick;

    // Reference model state
    logic [9:0] mx, my;
    logic [3:0] mdx, mdy;
    int         mcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic cycle();
        logic mt;
        exp_t e;
        #1;
        mt = reset_n && en && (mcnt == 3);
        check("tick", sprite_update_tick, mt);
        last_tick = sprite_update_tick;
        if (sprite_update_tick === 1'b1) ticks++;
        if (!reset_n) begin
            mx = 0; my = 0; mdx = 0; mdy = 0; mcnt = 0;
        end else begin
            if (wxy) begin
                mx = wx; my = wy;
            end else if (mt) begin
                mx = mx + 10'($signed(mdx));
                my = my + 10'($signed(mdy));
            end
            if (wdxy) begin
                mdx = wdx; mdy = wdy;
            end
            mcnt = (!en || mcnt == 3) ? 0 : mcnt + 1;
        end
        e.x = mx;
        e.y = my;
        e.w = (mx <= 10'd632) && (my <= 10'd472);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check("x", sprite_x, e.x);
        check("y", sprite_y, e.y);
        check("within", sprite_within_screen, e.w);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Loads position and velocity with motion disabled (counter cleared).
    task automatic setup(input logic [9:0] x, input logic [9:0] y,
                         input logic [3:0] dx, input logic [3:0] dy);
        en = 0; wxy = 1; wdxy = 1; wx = x; wy = y; wdx = dx; wdy = dy;
        cycle();
        wxy = 0; wdxy = 0;
        ticks = 0;
    endtask

    initial begin
        mx = 0; my = 0; mdx = 0; mdy = 0; mcnt = 0;
        reset_n = 0; wxy = 0; wdxy = 0; en = 0;
        wx = 0; wy = 0; wdx = 0; wdy = 0;
        @(negedge clk);
        run(2);
        check("rst_x", sprite_x, 0);
        check("rst_y", sprite_y, 0);
        check("rst_within", sprite_within_screen, 1);
        reset_n = 1;

        // Two steps of (+3,-2) from (100,200)
        setup(10'd100, 10'd200, 4'd3, 4'hE);
        en = 1;
        run(4);
        check("t1_first_tick", last_tick, 1);
        run(4);
        check("t1_ticks", ticks, 2);
        check("t1_x", sprite_x, 106);
        check("t1_y", sprite_y, 196);
        check("t1_within", sprite_within_screen, 1);

        // Right edge crossing changes within together with x
        setup(10'd632, 10'd10, 4'd1, 4'd0);
        en = 1;
        run(3);
        check("t2_within_before", sprite_within_screen, 1);
        run(1);
        check("t2_x", sprite_x, 633);
        check("t2_within", sprite_within_screen, 0);

        // Wrap below zero
        setup(10'd1, 10'd0, 4'hE, 4'd0);
        en = 1;
        run(4);
        check("t3_x", sprite_x, 1023);
        check("t3_within", sprite_within_screen, 0);

        // Position write in the tick cycle wins; counter keeps its phase
        setup(10'd10, 10'd10, 4'd1, 4'd1);
        en = 1;
        run(3);
        wxy = 1; wx = 10'd50; wy = 10'd50;
        cycle();
        wxy = 0;
        check("t4_tick_cycle", last_tick, 1);
        check("t4_x", sprite_x, 50);
        check("t4_y", sprite_y, 50);
        ticks = 0;
        run(3);
        check("t4_no_tick", ticks, 0);
        run(1);
        check("t4_next_tick", ticks, 1);
        check("t4_x2", sprite_x, 51);

        // Enable dropout restarts the count
        setup(10'd20, 10'd20, 4'd1, 4'd0);
        en = 1; run(3);
        en = 0; run(1);
        en = 1; run(3);
        check("t5_no_tick", ticks, 0);
        check("t5_x_hold", sprite_x, 20);
        run(1);
        check("t5_tick", ticks, 1);
        check("t5_x", sprite_x, 21);

        // Reset mid-motion overrides writes and clears velocity
        setup(10'd300, 10'd300, 4'd1, 4'd1);
        en = 1; run(2);
        reset_n = 0; wxy = 1; wx = 10'd5; wy = 10'd5; wdxy = 1; wdx = 4'd2; wdy = 4'd2;
        cycle();
        reset_n = 1; wxy = 0; wdxy = 0;
        check("t6_x", sprite_x, 0);
        check("t6_y", sprite_y, 0);
        check("t6_within", sprite_within_screen, 1);
        #1;
        check("t6_tick", sprite_update_tick, 0);
        ticks = 0;
        run(3);
        check("t6_no_tick", ticks, 0);
        run(1);
        check("t6_tick_after", ticks, 1);
        check("t6_still_x", sprite_x, 0);
        check("t6_still_y", sprite_y, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/game_sprite_motion.md
GAME_SPRITE_MOTION -- requirements
Module: game_sprite_motion

Interface
Parameters:
REQ-001 The block SHALL take parameter X_WIDTH, default 10, the width of the X coordinate.
REQ-002 The block SHALL take parameter Y_WIDTH, default 10, the width of the Y coordinate.
REQ-003 The block SHALL take parameter D_WIDTH, default 4, the width of signed dx/dy.
REQ-004 The block SHALL take parameters SCREEN_W and SCREEN_H, defaults 640 and 480, the visible area in pixels.
REQ-005 The block SHALL take parameters SPRITE_W and SPRITE_H, defaults 8 and 8, the sprite size in pixels.
REQ-006 The block SHALL take parameter UPDATE_PERIOD, default 100000, the clock cycles per motion step (>=2).

Ports:
REQ-007 The block SHALL have clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have reset_n, input, 1 bit: synchronous, active-low reset.
REQ-009 The block SHALL have sprite_write_xy, input, 1 bit: load position from sprite_write_x/sprite_write_y.
REQ-010 The block SHALL have sprite_write_x, input, X_WIDTH bits, and sprite_write_y, input, Y_WIDTH bits: the position to load, unsigned.
REQ-011 The block SHALL have sprite_write_dxy, input, 1 bit: load velocity from sprite_write_dx/sprite_write_dy.
REQ-012 The block SHALL have sprite_write_dx and sprite_write_dy, input, D_WIDTH bits each: velocity, two's complement.
REQ-013 The block SHALL have sprite_enable_update, input, 1 bit: allow periodic motion.
REQ-014 The block SHALL have sprite_x, output, X_WIDTH bits, and sprite_y, output, Y_WIDTH bits: the current position, registered.
REQ-015 The block SHALL have sprite_within_screen, output, 1 bit: the sprite lies fully inside the screen, registered.
REQ-016 The block SHALL have sprite_update_tick, output, 1 bit: a one-cycle pulse marking the cycle a motion step is applied.

Function
REQ-017 The step counter SHALL count 0..UPDATE_PERIOD-1 while sprite_enable_update=1, wrapping to 0, and SHALL be forced to 0 in every cycle where sprite_enable_update=0.
REQ-018 sprite_update_tick SHALL be 1 exactly in cycles where sprite_enable_update=1 and the counter equals UPDATE_PERIOD-1, giving the first tick UPDATE_PERIOD cycles after enable rises.
REQ-019 On a tick, next x SHALL be x + sign-extended dx modulo 2^X_WIDTH, and next y SHALL be y + sign-extended dy modulo 2^Y_WIDTH (wrap-around, no saturation).
REQ-020 sprite_write_xy=1 SHALL load the position on the next edge and SHALL take priority over a simultaneous tick; that step is discarded and the counter is unaffected.
REQ-021 sprite_write_dxy=1 SHALL load dx/dy on the next edge, independent of position writes; a tick in the same cycle SHALL use the old dx/dy.
REQ-022 sprite_within_screen SHALL equal (x <= SCREEN_W-SPRITE_W) and (y <= SCREEN_H-SPRITE_H), unsigned compare, evaluated on the next-state position and registered so it updates in the same edge as sprite_x/sprite_y.
REQ-023 A position wrapping below 0 SHALL appear as a large unsigned value and therefore SHALL report out of screen.
REQ-024 The block SHALL have no other state; dx=dy=0 with enable high SHALL produce ticks without moving.

Reset
REQ-025 With reset_n=0 at a rising edge, sprite_x, sprite_y, dx, dy and the counter SHALL become 0, sprite_update_tick SHALL be 0 and sprite_within_screen SHALL be 1, regardless of other inputs.
REQ-026 Reset SHALL take priority over writes and ticks; asserting it mid-motion SHALL abandon the step in progress, and the first tick after release SHALL come UPDATE_PERIOD enabled cycles later.

Verification (UPDATE_PERIOD=4, other parameters at defaults)
REQ-027 Reset, then write_xy (100,200), write_dxy (+3,-2), enable held -> ticks every 4 cycles; after 2 ticks the position is (106,196) and within_screen=1.
REQ-028 Position (632,10), dx=+1, enable -> after 1 tick x=633 and within_screen=0 in the same cycle x changes.
REQ-029 Position (1,0), dx=-2, dy=0, enable -> after 1 tick x=1023 and within_screen=0.
REQ-030 write_xy (50,50) asserted in the tick cycle -> position becomes (50,50), the step is lost, and the next tick comes 4 cycles later.
REQ-031 Enable dropped for 1 cycle after 3 enabled cycles -> no tick; the counter restarts and the next tick comes 4 cycles after re-enable.
REQ-032 reset_n=0 for 1 cycle mid-motion at (300,300) -> next cycle the position is (0,0), dx=dy=0, within_screen=1 and tick=0.
